// File: rtl/time_set_ctrl.sv
// Time-set controller for the HH:MM:SS clock: button debounce, edit FSM, display mux,
// field blink and the one-cycle load pulse into the time counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | time counter running, live time shown
//   SET_HOUR | counter halted, INC steps hour_e, hour digits blink
//   SET_MIN  | counter halted, INC steps min_e, minute digits blink
//   COMMIT   | single cycle, load pulse with hour_e:min_e:00
module time_set_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int BLINK_CYC    = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_neg,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  input  logic [5:0] cur_sec,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hour,
  output logic       run_en,
  output logic       load,
  output logic [5:0] load_sec,
  output logic [5:0] load_min,
  output logic [4:0] load_hour,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic [4:0] disp_hour,
  output logic [5:0] blank_mask,
  output logic [1:0] edit_state
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int BW = $clog2(BLINK_CYC + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // bit 0 = MODE, bit 1 = INC; all levels active-low, idle high
  logic [1:0]         sync1, sync2, deb, press;
  logic [1:0][DW-1:0] db_cnt;
  logic               mode_ev, inc_ev;

  logic [4:0]    hour_e;
  logic [5:0]    min_e;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          enter_edit;

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      deb    <= 2'b11;
      db_cnt <= '0;
    end else begin
      sync1 <= {btn_inc_n, btn_mode_n};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        // reload on the edge where the synced level is about to change
        if (sync1[i] != sync2[i])
          db_cnt[i] <= DW'(DEBOUNCE_CYC - 1);
        else if (db_cnt[i] != '0)
          db_cnt[i] <= db_cnt[i] - 1'b1;
        if (db_cnt[i] == '0)
          deb[i] <= sync2[i];
      end
    end
  end

  always_comb begin
    press = 2'b00;
    for (int i = 0; i < 2; i++)
      press[i] = (db_cnt[i] == '0) && (sync2[i] != deb[i]) && !sync2[i];
  end

  assign mode_ev = press[0];
  assign inc_ev  = press[1];

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (mode_ev) state_d = ST_SET_HOUR;
      ST_SET_HOUR: if (mode_ev) state_d = ST_SET_MIN;
      ST_SET_MIN:  if (mode_ev) state_d = ST_COMMIT;
      ST_COMMIT:   state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      hour_e    <= '0;
      min_e     <= '0;
      load_hour <= '0;
      load_min  <= '0;
    end else begin
      case (state_q)
        ST_RUN: if (mode_ev) begin
          hour_e <= (cur_hour > 5'd23) ? 5'd0 : cur_hour;
          min_e  <= (cur_min > 6'd59) ? 6'd0 : cur_min;
        end
        ST_SET_HOUR: if (inc_ev && !mode_ev)
          hour_e <= (hour_e == 5'd23) ? 5'd0 : hour_e + 5'd1;
        ST_SET_MIN: begin
          if (mode_ev) begin
            load_hour <= hour_e;
            load_min  <= min_e;
          end else if (inc_ev) begin
            min_e <= (min_e == 6'd59) ? 6'd0 : min_e + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_sec = 6'd0;

  // blink restarts on field entry so the edited field is visible first
  assign enter_edit = (state_d != state_q) &&
                      ((state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN));

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (enter_edit) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYC - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    run_en     = (state_q == ST_RUN);
    load       = (state_q == ST_COMMIT);
    edit_state = state_q;
    blank_mask = 6'b000000;
    disp_hour  = hour_e;
    disp_min   = min_e;
    disp_sec   = 6'd0;
    if (state_q == ST_RUN) begin
      disp_hour = cur_hour;
      disp_min  = cur_min;
      disp_sec  = cur_sec;
    end
    if (blink_ph && state_q == ST_SET_HOUR) blank_mask = 6'b110000;
    if (blink_ph && state_q == ST_SET_MIN)  blank_mask = 6'b001100;
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce and blink periods.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;

  logic       clk = 1'b0;
  logic       rst_neg;
  logic       btn_mode_n, btn_inc_n;
  logic [5:0] cur_sec, cur_min;
  logic [4:0] cur_hour;
  logic       run_en, load;
  logic [5:0] load_sec, load_min, disp_sec, disp_min, blank_mask;
  logic [4:0] load_hour, disp_hour;
  logic [1:0] edit_state;

  int ncmp = 0;
  int nerr = 0;
  int load_pulses = 0;
  int load_base;

  time_set_ctrl #(.DEBOUNCE_CYC(DEB), .BLINK_CYC(BLK)) dut (
    .clk(clk), .rst_neg(rst_neg),
    .btn_mode_n(btn_mode_n), .btn_inc_n(btn_inc_n),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .run_en(run_en), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
    .disp_sec(disp_sec), .disp_min(disp_min), .disp_hour(disp_hour),
    .blank_mask(blank_mask), .edit_state(edit_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) load_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench sampling just after the edge on which the event takes effect
  task automatic press_start(input logic m, input logic i);
    tick();
    btn_mode_n = ~m;
    btn_inc_n  = ~i;
    repeat (DEB + 2) tick();
  endtask

  task automatic press_finish();
    tick();
    btn_mode_n = 1'b1;
    btn_inc_n  = 1'b1;
    repeat (12) tick();
  endtask

  task automatic set_cur(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    cur_hour = h;
    cur_min  = m;
    cur_sec  = s;
  endtask

  initial begin
    rst_neg    = 1'b0;
    btn_mode_n = 1'b1;
    btn_inc_n  = 1'b1;
    set_cur(5'd12, 6'd34, 6'd56);

    // 1: reset state
    #12;
    chk("rst_run_en", 32'(run_en), 1);
    chk("rst_load", 32'(load), 0);
    chk("rst_blank", 32'(blank_mask), 0);
    chk("rst_state", 32'(edit_state), 0);
    chk("rst_disp_h", 32'(disp_hour), 12);
    chk("rst_disp_m", 32'(disp_min), 34);
    chk("rst_disp_s", 32'(disp_sec), 56);
    chk("rst_load_h", 32'(load_hour), 0);
    tick();
    rst_neg = 1'b1;
    repeat (3) tick();
    chk("run_disp_s", 32'(disp_sec), 56);

    // 2: bounce rejected, then a real press lands 2+DEB cycles after the edge
    tick();
    btn_mode_n = 1'b0;
    repeat (2) tick();
    btn_mode_n = 1'b1;
    repeat (10) tick();
    chk("bounce_state", 32'(edit_state), 0);
    tick();
    btn_mode_n = 1'b0;
    repeat (5) tick();
    chk("press_lat5", 32'(edit_state), 0);
    tick();
    chk("press_lat6", 32'(edit_state), 1);
    tick();
    btn_mode_n = 1'b1;
    repeat (12) tick();
    chk("held_state", 32'(edit_state), 1);
    chk("sh_run_en", 32'(run_en), 0);
    chk("sh_disp_h", 32'(disp_hour), 12);
    chk("sh_disp_m", 32'(disp_min), 34);
    chk("sh_disp_s", 32'(disp_sec), 0);
    press_start(1, 0);
    chk("to_setmin", 32'(edit_state), 2);
    press_finish();
    press_start(1, 0);
    chk("c1_load", 32'(load), 1);
    chk("c1_state", 32'(edit_state), 3);
    chk("c1_run_en", 32'(run_en), 0);
    chk("c1_load_h", 32'(load_hour), 12);
    chk("c1_load_m", 32'(load_min), 34);
    chk("c1_load_s", 32'(load_sec), 0);
    press_finish();
    chk("c1_after_load", 32'(load), 0);
    chk("c1_after_run", 32'(run_en), 1);
    chk("c1_hold_h", 32'(load_hour), 12);
    chk("c1_pulses", 32'(load_pulses), 1);

    // INC ignored in RUN
    press_start(0, 1);
    chk("inc_in_run", 32'(edit_state), 0);
    press_finish();

    // 3: wrap of hour and minute
    set_cur(5'd23, 6'd59, 6'd30);
    press_start(1, 0);
    chk("w_state1", 32'(edit_state), 1);
    chk("w_disp_h23", 32'(disp_hour), 23);
    press_finish();
    press_start(0, 1);
    chk("w_hour_wrap", 32'(disp_hour), 0);
    press_finish();
    press_start(1, 0);
    chk("w_state2", 32'(edit_state), 2);
    chk("w_disp_m59", 32'(disp_min), 59);
    press_finish();
    press_start(0, 1);
    chk("w_min_wrap", 32'(disp_min), 0);
    press_finish();
    press_start(1, 0);
    chk("w_load", 32'(load), 1);
    chk("w_load_h", 32'(load_hour), 0);
    chk("w_load_m", 32'(load_min), 0);
    chk("w_blank_commit", 32'(blank_mask), 0);
    press_finish();
    chk("w_run_en", 32'(run_en), 1);
    chk("w_state0", 32'(edit_state), 0);

    // 4: blink pattern in SET_HOUR then SET_MIN, restarting visible on entry
    set_cur(5'd7, 6'd45, 6'd10);
    press_start(1, 0);
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("blink_h%0d", j), 32'(blank_mask), ((j / BLK) % 2) ? 32'h30 : 32'h00);
      if (j == 0) btn_mode_n = 1'b1;
      tick();
    end
    repeat (3) tick();
    press_start(1, 0);
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("blink_m%0d", j), 32'(blank_mask), ((j / BLK) % 2) ? 32'h0C : 32'h00);
      if (j == 0) btn_mode_n = 1'b1;
      tick();
    end
    press_start(1, 0);
    chk("b_commit_blank", 32'(blank_mask), 0);
    press_finish();
    chk("b_run_blank", 32'(blank_mask), 0);

    // 5: simultaneous MODE and INC, MODE wins
    set_cur(5'd5, 6'd20, 6'd0);
    press_start(1, 0);
    press_finish();
    chk("s_disp_h5", 32'(disp_hour), 5);
    press_start(1, 1);
    chk("s_state", 32'(edit_state), 2);
    chk("s_hour_kept", 32'(disp_hour), 5);
    press_finish();
    press_start(1, 0);
    chk("s_load_h", 32'(load_hour), 5);
    chk("s_load_m", 32'(load_min), 20);
    press_finish();

    // 6: reset mid-edit abandons without a load
    set_cur(5'd9, 6'd8, 6'd7);
    press_start(1, 0);
    press_finish();
    press_start(1, 0);
    press_finish();
    chk("r_in_setmin", 32'(edit_state), 2);
    load_base = load_pulses;
    #2;
    rst_neg = 1'b0;
    #1;
    chk("r_state", 32'(edit_state), 0);
    chk("r_run_en", 32'(run_en), 1);
    chk("r_load", 32'(load), 0);
    repeat (3) tick();
    rst_neg = 1'b1;
    repeat (20) tick();
    chk("r_no_load", 32'(load_pulses - load_base), 0);
    chk("r_state_after", 32'(edit_state), 0);
    chk("r_disp_h", 32'(disp_hour), 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
